// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 constants and types for the pipeline.
//   RNONE / RSP     : register-id constants used by the writeback path
//   I*              : instruction codes (kept here for the whole pipeline)
//   pend_t          : {dst, val} pending writeback entry at full register width
package y86_pkg;

    localparam int XLEN = 64;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef struct packed {
        logic [3:0]      dst;
        logic [XLEN-1:0] val;
    } pend_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// wb_pend_fifo: in-order pending-write FIFO, 2 writes in / 1 write out per cycle.
//   clk, reset            : clock, synchronous active-high reset
//   enq0_*, enq1_*        : up to two entries per cycle, slot 0 is older;
//                           enq1_en is only asserted together with enq0_en
//   head_valid/dst/val    : oldest entry; it is dequeued on every edge where
//                           head_valid is high (the consumer always takes it)
//   cnt                   : occupancy
//   look_*/hit_*/val_*    : combinational newest-match lookups for A, B, RSP
module wb_pend_fifo
    import y86_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq0_en,
    input  logic [3:0]        enq0_dst,
    input  logic [DATA_W-1:0] enq0_val,
    input  logic              enq1_en,
    input  logic [3:0]        enq1_dst,
    input  logic [DATA_W-1:0] enq1_val,
    output logic              head_valid,
    output logic [3:0]        head_dst,
    output logic [DATA_W-1:0] head_val,
    output logic [CW-1:0]     cnt,
    input  logic [3:0]        look_a,
    input  logic [3:0]        look_b,
    input  logic [3:0]        look_s,
    output logic              hit_a,
    output logic [DATA_W-1:0] val_a,
    output logic              hit_b,
    output logic [DATA_W-1:0] val_b,
    output logic              hit_s,
    output logic [DATA_W-1:0] val_s
);

    logic [3:0]        dst_mem [DEPTH];
    logic [DATA_W-1:0] val_mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              deq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Walk from the oldest entry to the newest so a later match overrides an
    // earlier one; ordering is by age, independent of where the pointers sit.
    function automatic logic [DATA_W:0] lookup(input logic [3:0] addr);
        logic [DATA_W:0] r;
        logic [PW-1:0]   idx;
        r   = '0;
        idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < cnt) && (dst_mem[idx] == addr)) begin
                r = {1'b1, val_mem[idx]};
            end
            idx = ptr_inc(idx);
        end
        return r;
    endfunction

    assign deq        = (cnt != '0);
    assign head_valid = deq;
    assign head_dst   = dst_mem[head];
    assign head_val   = val_mem[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (enq1_en) begin
                tail <= ptr_inc(ptr_inc(tail));
            end else if (enq0_en) begin
                tail <= ptr_inc(tail);
            end
            if (deq) begin
                head <= ptr_inc(head);
            end
            cnt <= cnt + CW'(enq0_en) + CW'(enq1_en) - CW'(deq);
        end
    end

    // Storage needs no reset: entries beyond cnt are never observed.
    always_ff @(posedge clk) begin
        if (enq0_en) begin
            dst_mem[tail] <= enq0_dst;
            val_mem[tail] <= enq0_val;
        end
        if (enq1_en) begin
            dst_mem[ptr_inc(tail)] <= enq1_dst;
            val_mem[ptr_inc(tail)] <= enq1_val;
        end
    end

    always_comb begin
        {hit_a, val_a} = lookup(look_a);
        {hit_b, val_b} = lookup(look_b);
        {hit_s, val_s} = lookup(look_s);
    end

endmodule

// File: rtl/wb_regfile_sched.sv
// wb_regfile_sched: 15-entry register file behind a pending-write scheduler.
//   clk, reset             : clock, synchronous active-high reset
//   w_valid / w_ready      : retiring-instruction handshake (see below)
//   w_dstE/w_valE          : E-port write, dst 4'hF = none
//   w_dstM/w_valM          : M-port write, dst 4'hF = none
//   srcA/srcB -> rdA/rdB   : decode reads, forwarded from pending writes
//   rsp                    : forwarded value of register 4
//   pend_cnt, busy         : buffer occupancy, occupancy != 0
//
// Handshake: an instruction transfers on a rising edge where w_valid and
// w_ready are both high. w_ready depends only on registered occupancy (and
// is held low during reset), never on w_valid or the destinations. While
// w_valid is high and w_ready low, the producer holds all w_* inputs stable.
module wb_regfile_sched
    import y86_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [3:0]        w_dstE,
    input  logic [DATA_W-1:0] w_valE,
    input  logic [3:0]        w_dstM,
    input  logic [DATA_W-1:0] w_valM,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] rdA,
    output logic [DATA_W-1:0] rdB,
    output logic [DATA_W-1:0] rsp,
    output logic [CW-1:0]     pend_cnt,
    output logic              busy
);

    logic [DATA_W-1:0] regs [15];

    logic              transfer;
    logic              e_want;
    logic              m_want;
    logic              enq0_en;
    logic [3:0]        enq0_dst;
    logic [DATA_W-1:0] enq0_val;
    logic              enq1_en;
    logic              head_valid;
    logic [3:0]        head_dst;
    logic [DATA_W-1:0] head_val;
    logic [CW-1:0]     cnt;
    logic              hit_a, hit_b, hit_s;
    logic [DATA_W-1:0] val_a, val_b, val_s;

    // Room for a two-write instruction is required before accepting any.
    assign w_ready  = !reset && (cnt <= CW'(DEPTH - 2));
    assign transfer = w_valid && w_ready;

    // When both ports target the same register (popq %rsp) only M survives.
    assign e_want = (w_dstE != RNONE) && (w_dstE != w_dstM);
    assign m_want = (w_dstM != RNONE);

    // Slot 0 is E when present, otherwise M; slot 1 is M behind E.
    assign enq0_en  = transfer && (e_want || m_want);
    assign enq0_dst = e_want ? w_dstE : w_dstM;
    assign enq0_val = e_want ? w_valE : w_valM;
    assign enq1_en  = transfer && e_want && m_want;

    wb_pend_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .enq0_en    (enq0_en),
        .enq0_dst   (enq0_dst),
        .enq0_val   (enq0_val),
        .enq1_en    (enq1_en),
        .enq1_dst   (w_dstM),
        .enq1_val   (w_valM),
        .head_valid (head_valid),
        .head_dst   (head_dst),
        .head_val   (head_val),
        .cnt        (cnt),
        .look_a     (srcA),
        .look_b     (srcB),
        .look_s     (RSP),
        .hit_a      (hit_a),
        .val_a      (val_a),
        .hit_b      (hit_b),
        .val_b      (val_b),
        .hit_s      (hit_s),
        .val_s      (val_s)
    );

    // Only real destinations are ever queued, so head_dst is always 0..14.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= DATA_W'(i);
            end
        end else if (head_valid) begin
            regs[head_dst] <= head_val;
        end
    end

    function automatic logic [DATA_W-1:0] rd_mux(input logic [3:0] addr,
                                                 input logic hit,
                                                 input logic [DATA_W-1:0] fwd);
        if (addr == RNONE) begin
            return '0;
        end else if (hit) begin
            return fwd;
        end
        return regs[addr];
    endfunction

    always_comb begin
        rdA = rd_mux(srcA, hit_a, val_a);
        rdB = rd_mux(srcB, hit_b, val_b);
        rsp = rd_mux(RSP, hit_s, val_s);
    end

    assign pend_cnt = cnt;
    assign busy     = (cnt != '0);

endmodule

// File: doc/wb_regfile_sched.md
# wb_regfile_sched

Single-write-port register file with a write scheduler for the pipeline's writeback stage. It accepts up to two register writes per retiring instruction (E port from the ALU/stack-pointer path, M port from memory) and queues them into a small pending buffer. It drains the buffer into the 15-entry register file at one write per cycle and forwards pending values to the decode read ports. It also throttles writeback with a ready signal when the buffer cannot absorb another instruction.

## Interface
- DEPTH, 4, pending-write buffer entries; must be ≥ 2
- DATA_W, 64, register width

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- w_valid  in  1  writeback stage presents a retiring instruction
- w_ready  out  1  scheduler accepts the instruction this cycle
- w_dstE  in  4  E-port destination; 4'hF = none
- w_valE  in  DATA_W  E-port value
- w_dstM  in  4  M-port destination; 4'hF = none
- w_valM  in  DATA_W  M-port value
- srcA, srcB  in  4  decode read addresses
- rdA, rdB  out  DATA_W  read data, forwarded
- rsp  out  DATA_W  current %rsp (reg 4), forwarded
- pend_cnt  out  $clog2(DEPTH+1)  buffer occupancy
- busy  out  1  pend_cnt != 0

## Operation
- Transfer on w_valid && w_ready. It enqueues nonempty writes in order: E first, then M.
- If w_dstE == w_dstM and both are not 4'hF, only M is enqueued. This is the popq %rsp rule, where the memory value wins.
- The buffer is an in-order FIFO of {dst, val}. The head is written to R[dst] when the buffer is nonempty, one entry per cycle.
- Enqueue (0–2 entries) and dequeue (0–1) may happen in the same cycle. Next count = count + enq − deq.
- w_ready = (DEPTH − pend_cnt) ≥ 2. It is derived from registered state only and does not depend on w_valid or w_dst*.
- A transfer with both dst = 4'hF (e.g. rmmovq, jXX, nop) is accepted and enqueues nothing.
- Reads:
  - For address 4'hF, rdA/rdB return 0.
  - Otherwise the read returns the value of the newest buffer entry whose dst matches.
  - If no entry matches, the read returns R[addr].
  - Same-cycle incoming writes are not forwarded. The pipeline bypass covers them.
- rsp follows the same forwarding as a read of address 4.
- No arithmetic beyond occupancy and pointer wrap. Pointers are modulo DEPTH, and the count saturates logically via w_ready.

## Timing
- Reset (while reset=1, next edge):
  - R[i] = i for i = 0..14.
  - Buffer emptied and pointers zeroed.
  - pend_cnt = 0, busy = 0.
  - w_ready forced 0 while reset is high, then 1 the cycle after it drops.
- Reset mid-operation discards all pending writes. The register file returns to its reset values.
- Latency:
  - Entries from an accepted instruction are visible on rdA/rdB/rsp in the next cycle via forwarding.
  - They are architecturally written after waiting behind older entries. Best case is the edge after enqueue.
  - A two-write instruction into an empty buffer is fully committed by edge +2.
- Full: at pend_cnt ≥ DEPTH−1, w_ready = 0. The pipeline holds its W stage and inputs must stay stable until accepted.
- Wrap-around: pointers wrap to 0 past DEPTH−1. Forwarding search is ordered by age, not by index.
- Read/drain collision: when a reg is read in the same cycle its only buffered entry drains, it is returned from the buffer value, which equals the committed value next cycle.

## Structure
- Shared package y86_pkg holds:
  - RNONE = 4'hF
  - RSP = 4'h4
  - icode constants (IRRMOVQ … IPOPQ), even though this block decodes no icode
  - a typedef for the {dst, val} pending entry
- Sub-module wb_pend_fifo is the natural split. It holds the FIFO with 2-in/1-out and exposes a combinational newest-match lookup for three addresses (A, B, RSP). The top level holds the register array, the ready logic and the read muxing.

## Test plan
- Reset, then read srcA=3, srcB=14 → rdA=3, rdB=14, rsp=4, w_ready=1, pend_cnt=0.
- irmovq: dstE=2, valE=0x55, dstM=F → next cycle rdA(2)=0x55 and pend_cnt=1. A cycle later pend_cnt=0 and R[2]=0x55.
- popq %rbx: dstE=4, valE=0x20, dstM=3, valM=0xAB → rsp=0x20 and rdA(3)=0xAB next cycle. Drains in order E then M over 2 cycles.
- popq %rsp: dstE=4, valE=0x28, dstM=4, valM=0x99 → one entry enqueued. rsp=0x99 and pend_cnt=1.
- DEPTH=4, back-to-back two-write instructions every cycle → w_ready drops when pend_cnt=3. No write is lost and the final R matches the last writer per register, across pointer wrap.
- Assert reset with pend_cnt=3 → next cycle pend_cnt=0, all R[i]=i, and forwarded reads return the reset values.
